// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants, state type and slot mapping for the TDM link
`timescale 1ns/1ps
package tdm_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = $clog2(NUM_CH);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } tdm_state_t;

  // Slot k of the serial frame carries bit k of the parallel word. The transmit
  // sequencer uses the same mapping, so both ends stay in step if it changes.
  function automatic logic [SEL_W-1:0] slot_to_bit(input logic [SEL_W-1:0] slot);
    return slot;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - slot index counter with load-to-1, increment and last-slot flag
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   load_one   - a slot-0 bit was taken, so the next slot is 1 (wins over inc)
//   inc        - a mid-frame bit was taken, advance modulo NUM_CH
//   cnt        - slot index the next accepted bit will fill
//   last       - cnt addresses slot NUM_CH-1
`timescale 1ns/1ps
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int NUM_CH = tdm_pkg::NUM_CH,
  parameter int SEL_W  = tdm_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_one,
  input  logic             inc,
  output logic [SEL_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load_one) begin
      cnt <= SEL_W'(1);
    end else if (inc) begin
      // Power-of-two slot count, so the natural rollover is the frame wrap.
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == SEL_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux_8.sv
// rtl/tdm_demux_8.sv - frame-synchronised serial-to-parallel TDM demultiplexer
//
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   ser_in      - serial bit for the current slot
//   ser_valid   - ser_in carries a slot bit this cycle
//   frame_sync  - with ser_valid, marks the bit as slot 0 of a new frame
//   data_out    - last completed frame, bit k = slot k
//   data_valid  - one-cycle pulse when data_out updates
//   sel_out     - slot index the next accepted bit will fill
//   busy        - a frame is partially received
//   frame_err   - one-cycle pulse on a stray bit or an early frame sync
`timescale 1ns/1ps
module tdm_demux_8
  import tdm_pkg::*;
#(
  parameter int NUM_CH = tdm_pkg::NUM_CH,
  parameter int SEL_W  = tdm_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_in,
  input  logic              ser_valid,
  input  logic              frame_sync,
  output logic [NUM_CH-1:0] data_out,
  output logic              data_valid,
  output logic [SEL_W-1:0]  sel_out,
  output logic              busy,
  output logic              frame_err
);

  tdm_state_t        state_q;
  tdm_state_t        state_n;
  logic [NUM_CH-1:0] asm_q;
  logic [NUM_CH-1:0] asm_next;
  logic              load_one;
  logic              inc;
  logic              publish;
  logic              err_d;
  logic              last_slot;

  tdm_slot_counter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_slot_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_one (load_one),
    .inc      (inc),
    .cnt      (sel_out),
    .last     (last_slot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Frame word with the current bit merged in; published directly on the last
  // slot so data_out carries the final bit with one cycle of latency.
  always_comb begin
    asm_next = asm_q;
    asm_next[slot_to_bit(sel_out)] = ser_in;
  end

  always_comb begin
    state_n  = state_q;
    load_one = 1'b0;
    inc      = 1'b0;
    publish  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ser_valid && frame_sync) begin
          load_one = 1'b1;
          state_n  = RECV;
        end else if (ser_valid) begin
          err_d = 1'b1;
        end
      end
      RECV: begin
        if (ser_valid && frame_sync) begin
          // Early sync: drop the partial frame and restart on this bit.
          load_one = 1'b1;
          err_d    = 1'b1;
        end else if (ser_valid) begin
          inc = 1'b1;
          if (last_slot) begin
            publish = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
    end else if (load_one) begin
      asm_q[slot_to_bit(SEL_W'(0))] <= ser_in;
    end else if (inc) begin
      asm_q <= asm_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= publish;
      frame_err  <= err_d;
      if (publish) begin
        data_out <= asm_next;
      end
    end
  end

  assign busy = (state_q == RECV);

endmodule

// File: tb/tb_tdm_demux_8.sv
// tb/tb_tdm_demux_8.sv - directed scoreboard bench for tdm_demux_8
`timescale 1ns/1ps
module tb_tdm_demux_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser_in;
  logic       ser_valid;
  logic       frame_sync;
  logic [7:0] data_out;
  logic       data_valid;
  logic [2:0] sel_out;
  logic       busy;
  logic       frame_err;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         dv_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] exp_q[$];
  int         dv_cyc[$];
  logic [7:0] mon_exp;

  tdm_demux_8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .frame_sync (frame_sync),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sel_out    (sel_out),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every data_valid pulse pops one expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_err === 1'b1) err_cnt++;
      if (data_valid === 1'b1) begin
        dv_cnt++;
        dv_cyc.push_back(cyc);
        total++;
        assert (exp_q.size() != 0)
        else begin
          bad++;
          $error("FAIL valid_unexpected obs=%h required=none", data_out);
        end
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          total++;
          assert (data_out === mon_exp)
          else begin
            bad++;
            $error("FAIL data_out obs=%h required=%h", data_out, mon_exp);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic b);
    ser_valid  = v;
    frame_sync = s;
    ser_in     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Sends one full frame; optional gap of gap_len idle cycles after slot gap_at.
  task automatic send_frame(input logic [7:0] word, input int gap_at, input int gap_len);
    exp_q.push_back(word);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, k == 0, word[k]);
      chk("sel_step", 32'(sel_out), 32'((k + 1) % 8));
      chk("busy_step", 32'(busy), 32'(k != 7));
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          step(1'b0, 1'b0, 1'b1);
          chk("sel_gap", 32'(sel_out), 32'(k + 1));
          chk("busy_gap", 32'(busy), 32'd1);
        end
      end
    end
    chk("dv_pulse", 32'(data_valid), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 32'(data_out), 32'd0);
    chk({tag, "_dv"}, 32'(data_valid), 32'd0);
    chk({tag, "_sel"}, 32'(sel_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    int dv0;
    int er0;
    int n0;
    logic [7:0] w;

    rst_n = 1'b0;
    ser_in = 1'b0;
    ser_valid = 1'b0;
    frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // 1: nominal frame, slots 0..7 = 1,0,0,0,1,0,1,1
    dv0 = dv_cnt; er0 = err_cnt;
    send_frame(8'b1101_0001, -1, 0);
    idle(1);
    chk("t1_dv_low", 32'(data_valid), 32'd0);
    chk("t1_hold", 32'(data_out), 32'hD1);
    chk("t1_dv_count", 32'(dv_cnt - dv0), 32'd1);

    // 2: same word with 3 idle cycles between slots 3 and 4
    dv0 = dv_cnt;
    send_frame(8'hD1, 3, 3);
    idle(2);
    chk("t2_dv_count", 32'(dv_cnt - dv0), 32'd1);

    // 3: back-to-back frames
    dv0 = dv_cnt; n0 = dv_cyc.size();
    send_frame(8'hD1, -1, 0);
    send_frame(8'h2E, -1, 0);
    idle(2);
    chk("t3_dv_count", 32'(dv_cnt - dv0), 32'd2);
    if (dv_cyc.size() >= n0 + 2)
      chk("t3_spacing", 32'(dv_cyc[n0 + 1] - dv_cyc[n0]), 32'd8);
    else
      chk("t3_spacing_missing", 32'(dv_cyc.size() - n0), 32'd2);
    chk("t3_no_err", 32'(err_cnt - er0), 32'd0);

    // 4: early sync after 5 bits, then a full 8'hA5
    dv0 = dv_cnt; er0 = err_cnt;
    w = 8'h5B;
    for (int k = 0; k < 5; k++) step(1'b1, k == 0, w[k]);
    chk("t4_sel_partial", 32'(sel_out), 32'd5);
    send_frame(8'hA5, -1, 0);
    idle(2);
    chk("t4_err_count", 32'(err_cnt - er0), 32'd1);
    chk("t4_dv_count", 32'(dv_cnt - dv0), 32'd1);
    chk("t4_data", 32'(data_out), 32'hA5);

    // 5: stray bit in IDLE
    dv0 = dv_cnt;
    step(1'b1, 1'b0, 1'b1);
    chk("t5_err", 32'(frame_err), 32'd1);
    chk("t5_sel", 32'(sel_out), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_data", 32'(data_out), 32'hA5);
    idle(1);
    chk("t5_err_clear", 32'(frame_err), 32'd0);
    chk("t5_dv_none", 32'(dv_cnt - dv0), 32'd0);

    // 6: reset mid-frame, then a clean 8'h3C frame
    w = 8'hFF;
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, w[k]);
    chk("t6_busy_before", 32'(busy), 32'd1);
    ser_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    dv0 = dv_cnt;
    send_frame(8'h3C, -1, 0);
    idle(2);
    chk("t6_dv_count", 32'(dv_cnt - dv0), 32'd1);
    chk("t6_data", 32'(data_out), 32'h3C);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux_8.md
Name: tdm_demux_8

Overview:
- Receive-side counterpart of the team's 8:1 mux when that mux is used as a time-division serializer. The mux is stepped through sel 0..7, putting data_in[k] on the line in slot k.
- This block samples the resulting 1-bit stream and routes slot k back to bit k of a parallel word.
- It tracks the slot index with a frame-synchronised counter and presents each completed 8-bit frame with a one-cycle valid pulse.
- It sits at the far end of the serial link, feeding parallel consumers.

Parameters:
- NUM_CH, 8, number of channels/slots per frame (must be a power of 2, >=2).
- SEL_W, 3, slot index width = clog2(NUM_CH).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ser_in  input  1  serial data bit for the current slot.
- ser_valid  input  1  ser_in carries a slot bit this cycle.
- frame_sync  input  1  qualifies ser_valid; marks the bit as slot 0 of a new frame.
- data_out  output  NUM_CH  last completed frame; bit k = slot k.
- data_valid  output  1  one-cycle pulse when data_out updates.
- sel_out  output  SEL_W  slot index the next accepted bit will fill.
- busy  output  1  high while a frame is partially received (state RECV).
- frame_err  output  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset (async assert, sync release) drives every output to 0:
  - data_out=0, data_valid=0, sel_out=0, busy=0, frame_err=0.
  - State=IDLE, internal assembly register=0.
- Bits are accepted only in cycles with ser_valid=1. Cycles with ser_valid=0 change nothing and are legal gaps mid-frame.
- State IDLE:
  - ser_valid & frame_sync: store ser_in at assembly[0], sel_out<=1, go RECV.
  - ser_valid & !frame_sync: bit dropped, stay IDLE, frame_err pulses next cycle.
- State RECV:
  - ser_valid & !frame_sync: store ser_in at assembly[sel_out], sel_out<=sel_out+1.
  - When the stored slot is NUM_CH-1:
    - next cycle data_out = full word including this bit, and data_valid=1 for that one cycle;
    - sel_out wraps to 0, state returns to IDLE, busy=0.
  - ser_valid & frame_sync (early sync): partial frame discarded, data_out unchanged, frame_err pulses next cycle. The bit is accepted as slot 0 of a new frame: assembly[0]<=ser_in, sel_out<=1, stay RECV.
- Latency: data_out/data_valid are registered and appear 1 cycle after the slot NUM_CH-1 bit is sampled.
- Back-to-back frames: the sync bit of the next frame may arrive the cycle after the last slot. It is accepted from IDLE with no bubble and no error.
- data_out holds its value until the next complete frame; incomplete or aborted frames never reach data_out.
- Assembly register bits not yet written in the current frame are don't-care internally. Only complete frames are published, so this is never visible.
- Reset asserted mid-frame: partial frame lost; all outputs return to their reset values immediately.
- sel_out arithmetic is modulo NUM_CH. No overflow state exists beyond the wrap.
- busy = (state == RECV).

Decomposition:
- Shared package tdm_pkg holds:
  - localparams NUM_CH=8, SEL_W=$clog2(NUM_CH);
  - state enum {IDLE, RECV};
  - the bit-k-equals-slot-k mapping constant, shared with the transmit-side mux sequencer.
- One natural sub-module: tdm_slot_counter (SEL_W-bit counter with sync-load-to-1, increment, and wrap flag on NUM_CH-1).
- Assembly register, output register and FSM stay in tdm_demux_8.

Test Plan:
1. Reset then nominal frame: with rst_n low, all outputs are 0. Release, then send 8 consecutive ser_valid cycles carrying slots 0..7 = 1,0,0,0,1,0,1,1, with frame_sync on slot 0 only. Required: the cycle after slot 7, data_out=8'b11010001, data_valid=1 for exactly 1 cycle. sel_out steps 1..7 then returns to 0.
2. Gapped frame: same word, with ser_valid=0 for 3 cycles between slots 3 and 4. Required: data_out=8'b11010001, data_valid=1 once; sel_out holds 4 during the gap; busy=1 throughout.
3. Back-to-back frames: 8'b11010001 then 8'b00101110, with the second frame's sync the cycle after the first's slot 7. Required: two data_valid pulses 8 cycles apart, carrying 8'hD1 then 8'h2E; frame_err=0.
4. Early sync: send 5 bits of a frame, then a new frame_sync followed by 8'hA5 bits. Required: frame_err pulses once, with no data_valid for the aborted frame; then data_out=8'hA5.
5. Stray bit: ser_valid=1, frame_sync=0 in IDLE. Required: frame_err pulses 1 cycle later, sel_out stays 0, busy stays 0, data_out unchanged.
6. Reset mid-frame: assert rst_n after 4 bits. Required: all outputs are 0 immediately. After release, a full 8'h3C frame yields data_out=8'h3C with a single data_valid.
